// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: single-cycle MULT/MULTU/MTHI/MTLO, 32-step restoring divider,
// owns the HI/LO architectural registers.
module md_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  idex_md_op,
    input  logic [31:0] idex_rs_data,
    input  logic [31:0] idex_rt_data,
    input  logic        md_flush,
    output logic [31:0] md_res,
    output logic        md_busy,
    output logic        md_stall,
    output logic [31:0] md_hi,
    output logic [31:0] md_lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [3:0] OP_MUL   = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] quot_q, quot_d, rem_q, rem_d, divisor_q, divisor_d;
    logic        qsign_q, qsign_d, rsign_q, rsign_d, div0_q, div0_d;

    logic [63:0] prod_signed_s, prod_unsigned_s;
    logic [32:0] rem_shift_s, rem_sub_s;
    logic        ge_s, hilo_op_s, accept_s, sa_s, sb_s;

    assign prod_signed_s   = $signed(idex_rs_data) * $signed(idex_rt_data);
    assign prod_unsigned_s = idex_rs_data * idex_rt_data;

    // One restoring step: shift the next dividend bit into the remainder and trial-subtract.
    assign rem_shift_s = {rem_q, quot_q[31]};
    assign ge_s        = (rem_shift_s >= {1'b0, divisor_q});
    assign rem_sub_s   = rem_shift_s - {1'b0, divisor_q};

    assign hilo_op_s = (idex_md_op >= OP_MULT) && (idex_md_op <= OP_MFLO);
    assign md_busy   = (state_q != ST_IDLE);
    assign md_stall  = md_busy && hilo_op_s;
    assign accept_s  = (hilo_op_s || (idex_md_op == OP_MUL)) && !md_flush && !md_stall;
    assign md_hi     = hi_q;
    assign md_lo     = lo_q;

    // Combinational result mux; MF ops read register state without bypass.
    always_comb begin
        md_res = 32'd0;
        case (idex_md_op)
            OP_MFHI: md_res = hi_q;
            OP_MFLO: md_res = lo_q;
            OP_MUL:  md_res = prod_signed_s[31:0];
            default: md_res = 32'd0;
        endcase
    end

    // Next-state logic for the divider FSM and HI/LO writes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        div0_d    = div0_q;
        sa_s      = (idex_md_op == OP_DIV) && idex_rs_data[31];
        sb_s      = (idex_md_op == OP_DIV) && idex_rt_data[31];

        if (accept_s) begin
            case (idex_md_op)
                OP_MULT:  {hi_d, lo_d} = prod_signed_s;
                OP_MULTU: {hi_d, lo_d} = prod_unsigned_s;
                OP_MTHI:  hi_d = idex_rs_data;
                OP_MTLO:  lo_d = idex_rs_data;
                default:  hi_d = hi_q;
            endcase
        end else begin
            hi_d = hi_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s && ((idex_md_op == OP_DIV) || (idex_md_op == OP_DIVU))) begin
                    quot_d    = sa_s ? (32'd0 - idex_rs_data) : idex_rs_data;
                    divisor_d = sb_s ? (32'd0 - idex_rt_data) : idex_rt_data;
                    rem_d     = 32'd0;
                    cnt_d     = 5'd31;
                    qsign_d   = sa_s ^ sb_s;
                    rsign_d   = sa_s;
                    div0_d    = (idex_rt_data == 32'd0);
                    state_d   = ST_ITER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ITER: begin
                quot_d = {quot_q[30:0], ge_s};
                rem_d  = ge_s ? rem_sub_s[31:0] : rem_shift_s[31:0];
                if (cnt_q == 5'd0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_FIX: begin
                // Divide-by-zero remainder already equals the original dividend after sign fix.
                lo_d    = div0_q ? 32'hFFFF_FFFF : (qsign_q ? (32'd0 - quot_q) : quot_q);
                hi_d    = rsign_q ? (32'd0 - rem_q) : rem_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and architectural register update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            quot_q    <= 32'd0;
            rem_q     <= 32'd0;
            divisor_q <= 32'd0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            qsign_q   <= qsign_d;
            rsign_q   <= rsign_d;
            div0_q    <= div0_d;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with hand-computed expected values.
module tb_md_unit;

    logic        clk;
    logic        rst;
    logic [3:0]  idex_md_op;
    logic [31:0] idex_rs_data;
    logic [31:0] idex_rt_data;
    logic        md_flush;
    logic [31:0] md_res;
    logic        md_busy;
    logic        md_stall;
    logic [31:0] md_hi;
    logic [31:0] md_lo;

    int checks_cnt;
    int fail_cnt;
    int n;

    md_unit dut (
        .clk          (clk),
        .rst          (rst),
        .idex_md_op   (idex_md_op),
        .idex_rs_data (idex_rs_data),
        .idex_rt_data (idex_rt_data),
        .md_flush     (md_flush),
        .md_res       (md_res),
        .md_busy      (md_busy),
        .md_stall     (md_stall),
        .md_hi        (md_hi),
        .md_lo        (md_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt = checks_cnt + 1;
        if (got !== exp) begin
            fail_cnt = fail_cnt + 1;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        idex_md_op   = op;
        idex_rs_data = a;
        idex_rt_data = b;
    endtask

    // Accept a divide at the next edge, then count busy cycles with a bound.
    task automatic run_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int busy_cycles);
        drive(op, a, b);
        step();
        drive(4'd0, 32'd0, 32'd0);
        busy_cycles = 0;
        while (md_busy && busy_cycles < 100) begin
            busy_cycles = busy_cycles + 1;
            step();
        end
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst        = 1'b1;
        md_flush   = 1'b0;
        drive(4'd0, 32'd0, 32'd0);
        step();
        step();
        check_val("rst_hi", md_hi, 32'd0);
        check_val("rst_lo", md_lo, 32'd0);
        check_val("rst_busy", {31'd0, md_busy}, 32'd0);
        check_val("rst_res", md_res, 32'd0);
        check_val("rst_stall", {31'd0, md_stall}, 32'd0);
        rst = 1'b0;
        step();

        drive(4'd1, 32'hFFFF_FFFE, 32'h0000_0003);
        step();
        drive(4'd0, 32'd0, 32'd0);
        check_val("mult_hi", md_hi, 32'hFFFF_FFFF);
        check_val("mult_lo", md_lo, 32'hFFFF_FFFA);

        drive(4'd2, 32'hFFFF_FFFE, 32'h0000_0003);
        step();
        drive(4'd0, 32'd0, 32'd0);
        check_val("multu_hi", md_hi, 32'h0000_0002);
        check_val("multu_lo", md_lo, 32'hFFFF_FFFA);

        run_div(4'd3, 32'hFFFF_FFF9, 32'd2, n);
        check_val("div_busy_cycles", n, 32'd33);
        check_val("div_busy_low", {31'd0, md_busy}, 32'd0);
        check_val("div_lo", md_lo, 32'hFFFF_FFFD);
        check_val("div_hi", md_hi, 32'hFFFF_FFFF);

        run_div(4'd4, 32'd100, 32'd0, n);
        check_val("divu0_busy_cycles", n, 32'd33);
        check_val("divu0_hi", md_hi, 32'd100);
        check_val("divu0_lo", md_lo, 32'hFFFF_FFFF);

        run_div(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        check_val("divovf_lo", md_lo, 32'h8000_0000);
        check_val("divovf_hi", md_hi, 32'd0);

        run_div(4'd3, 32'hFFFF_FFF9, 32'd0, n);
        check_val("div0_neg_hi", md_hi, 32'hFFFF_FFF9);
        check_val("div0_neg_lo", md_lo, 32'hFFFF_FFFF);

        // DIVU 50/7 with a MUL probe and a held MFLO during the busy window.
        drive(4'd4, 32'd50, 32'd7);
        step();
        drive(4'd9, 32'd6, 32'd7);
        #1;
        check_val("mul_res", md_res, 32'd42);
        check_val("mul_nostall", {31'd0, md_stall}, 32'd0);
        check_val("mul_busy", {31'd0, md_busy}, 32'd1);
        drive(4'd8, 32'd0, 32'd0);
        #1;
        n = 0;
        while (md_stall && n < 100) begin
            n = n + 1;
            step();
        end
        check_val("mflo_stall_cycles", n, 32'd33);
        check_val("mflo_res", md_res, 32'd7);
        step();
        drive(4'd7, 32'd0, 32'd0);
        #1;
        check_val("mfhi_res", md_res, 32'd1);
        step();

        drive(4'd5, 32'h0000_1234, 32'd0);
        md_flush = 1'b1;
        step();
        md_flush = 1'b0;
        drive(4'd0, 32'd0, 32'd0);
        check_val("flush_hi", md_hi, 32'd1);
        drive(4'd5, 32'h0000_1234, 32'd0);
        step();
        drive(4'd0, 32'd0, 32'd0);
        check_val("mthi_hi", md_hi, 32'h0000_1234);
        check_val("mthi_lo_kept", md_lo, 32'd7);

        // Reset in the 10th ITER cycle of a divide.
        drive(4'd4, 32'd1000, 32'd3);
        step();
        drive(4'd0, 32'd0, 32'd0);
        for (int i = 0; i < 9; i++) step();
        check_val("pre_rst_busy", {31'd0, md_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("midrst_busy", {31'd0, md_busy}, 32'd0);
        check_val("midrst_hi", md_hi, 32'd0);
        check_val("midrst_lo", md_lo, 32'd0);
        step();
        rst = 1'b0;
        drive(4'd6, 32'd5, 32'd0);
        step();
        drive(4'd0, 32'd0, 32'd0);
        check_val("mtlo_lo", md_lo, 32'd5);
        check_val("mtlo_hi_kept", md_hi, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit in the EX stage of the pipeline CPU. It consumes the 4-bit `idex_md_op` code produced by the ID-stage decoder together with the rs/rt operands, and it owns the HI/LO architectural registers. MULT/MULTU/MTHI/MTLO complete in one cycle. DIV/DIVU run on an iterative 32-step radix-2 divider that stalls the pipeline through `md_stall` while busy.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `idex_md_op`  in  4  op code:
  - 0000 none
  - 0001 MULT
  - 0010 MULTU
  - 0011 DIV
  - 0100 DIVU
  - 0101 MTHI
  - 0110 MTLO
  - 0111 MFHI
  - 1000 MFLO
  - 1001 MUL
  - 1010–1111 treated as none
- `idex_rs_data`  in  32  operand A (dividend / multiplicand / MTHI/MTLO source).
- `idex_rt_data`  in  32  operand B (divisor / multiplier).
- `md_flush`  in  1  kill the op presented this cycle (exception/branch squash).
- `md_res`  out  32  combinational result:
  - HI for MFHI; LO for MFLO.
  - Low 32 bits of the signed product for MUL.
  - 0 otherwise.
- `md_busy`  out  1  divider iterating.
- `md_stall`  out  1  `md_busy` AND op ∈ {0001..1000}; freezes IF/ID/EX.
- `md_hi`, `md_lo`  out  32 each  current HI/LO register contents.

## Operation
- **Accept.** An op is accepted on a rising edge when all of the following hold:
  - op ≠ none
  - `md_flush` = 0
  - `md_stall` = 0
- **MUL.** Never stalls and never touches HI/LO. It is valid even while `md_busy` = 1.
- **MULT.** Signed 32×32→64 product. {HI, LO} are written at the accepting edge.
- **MULTU.** Unsigned 32×32→64 product. {HI, LO} are written at the accepting edge.
- **MTHI / MTLO.** Write HI or LO respectively at the accepting edge. The other register is unchanged.
- **MFHI / MFLO.** Read only. `md_res` reflects register contents as of the start of the cycle; there is no same-cycle bypass. Forwarding of an older MTHI/MULT is resolved because those ops write at the edge, before the MF op reaches EX.
- **DIV / DIVU.** FSM with three states: IDLE → ITER → FIX → IDLE.
  - **IDLE.**
    - On accept, latch the operands' absolute values (DIV) or the raw operands (DIVU).
    - Latch the sign flags: quotient sign = sa^sb, remainder sign = sa (DIV only).
    - Clear the remainder accumulator and set the counter to 31.
    - Go to ITER.
  - **ITER.** Performs one restoring shift-subtract step per cycle for 32 cycles (counter 31→0), then goes to FIX.
  - **FIX.**
    - Apply the sign corrections (two's-complement negate).
    - Write LO = quotient and HI = remainder.
    - Return to IDLE.
  - **Divide by zero**, signed or unsigned: HI = `idex_rs_data` as latched, LO = 0xFFFFFFFF.
  - **Signed overflow** 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This is the natural result of the algorithm.
- `md_busy` = 1 in the ITER and FIX states.
- **Flush.** `md_flush` only suppresses acceptance in its own cycle. It never aborts a divide already in ITER/FIX.
- **HI/LO ops while busy.** These raise `md_stall` and are not accepted; the pipeline re-presents them each cycle until busy drops.

## Timing
- **Reset** (async, any state, including mid-divide): FSM = IDLE, HI = LO = 0, counter = 0, `md_busy` = 0. `md_res` and `md_stall` are then 0 for op = none.
- **MULT/MULTU/MTHI/MTLO:** latency 1. Values are visible on `md_hi`/`md_lo` in the cycle after the accepting edge.
- **DIV/DIVU:** accepted at edge E.
  - `md_busy` is high in cycles E+1 … E+33: 32 ITER cycles plus 1 FIX cycle.
  - HI/LO are written at edge E+33.
  - `md_busy` is low from cycle E+34.
  - An MFLO held behind the divide is accepted at edge E+34 and reads the new quotient.
- **Back-to-back:** a new DIV may be accepted in the first cycle `md_busy` is low.
- **`md_stall`** is purely combinational from the current state and `idex_md_op`. It has no registered delay.

## Test plan
- MULT with rs = 0xFFFFFFFE (−2), rt = 0x00000003 → next cycle HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. The same operands with MULTU → HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV with rs = 0xFFFFFFF9 (−7), rt = 2 at edge E → `md_busy` high in cycles E+1 … E+33. After edge E+33, LO = 0xFFFFFFFD (−3) and HI = 0xFFFFFFFF (−1). `md_busy` = 0 in cycle E+34.
- DIVU 100/0 → HI = 100, LO = 0xFFFFFFFF after 33 busy cycles. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Start DIVU 50/7, then present MFLO and hold it 33 cycles with `md_stall` = 1. In the same window, a MUL 6×7 gives `md_res` = 42 with no stall. After the stall releases, MFLO gives `md_res` = 7; later, MFHI gives 1.
- Flush and reset:
  - MTHI 0x1234 with `md_flush` = 1 → HI unchanged.
  - Assert `rst` in the 10th ITER cycle of a DIV → busy, HI and LO are 0 immediately. After release, MTLO 5 → LO = 5 one cycle later.
